// File: rtl/bbs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bbs_pkg
// Description : Shared constants, FSM state type and helpers for the
//               Blum-Blum-Shub sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package bbs_pkg;

    localparam int unsigned X_W    = 64;
    localparam int unsigned PROD_W = 128;

    localparam logic [X_W-1:0] P       = 64'd2147483647;
    localparam logic [X_W-1:0] Q       = 64'd2147483629;
    localparam logic [X_W-1:0] N       = P * Q;
    localparam logic [X_W-1:0] X_RESET = 64'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SQUARE = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EMIT   = 3'd4
    } state_t;

    // Seeds 0 and 1 are fixed points of squaring, so they are replaced.
    function automatic logic [X_W-1:0] sanitize_seed(input logic [X_W-1:0] s);
        return (s <= 64'd1) ? X_RESET : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bbs_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : bbs_sequencer_if
// Description : Handshake bus between the BBS sequencer and the mod-n reducer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bbs_sequencer_if;

    logic                       mod_start;
    logic [bbs_pkg::PROD_W-1:0] mod_a;
    logic [bbs_pkg::X_W-1:0]    mod_result;
    logic                       mod_done;

    modport master (
        output mod_start,
        output mod_a,
        input  mod_result,
        input  mod_done
    );

    modport slave (
        input  mod_start,
        input  mod_a,
        output mod_result,
        output mod_done
    );

endinterface
`default_nettype wire

// File: rtl/bbs_square_mul.sv
`default_nettype none
// ============================================================================
// Module      : bbs_square_mul
// Description : Sequential shift-add squarer, one multiplier bit per cycle,
//               64 cycles, exact 128-bit product.
// Revision    : 1.0 - initial release
// ============================================================================
module bbs_square_mul
    import bbs_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [X_W-1:0]    a,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    logic              active_q, active_d;
    logic [5:0]        cnt_q,    cnt_d;
    logic [X_W-1:0]    mplier_q, mplier_d;
    logic [PROD_W-1:0] mcand_q,  mcand_d;
    logic [PROD_W-1:0] acc_q,    acc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            mplier_q <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
        end
    end

    // done is asserted during the cycle whose edge performs the last step,
    // so the product register is complete on the edge the caller sees done.
    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        mplier_d = mplier_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        done     = 1'b0;
        if (start) begin
            active_d = 1'b1;
            cnt_d    = '0;
            mplier_d = a;
            mcand_d  = {{(PROD_W-X_W){1'b0}}, a};
            acc_d    = '0;
        end else if (active_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
            if (cnt_q == 6'd63) begin
                active_d = 1'b0;
                done     = 1'b1;
            end
        end
    end

    assign product = acc_q;

endmodule
`default_nettype wire

// File: rtl/bbs_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bbs_sequencer
// Description : Blum-Blum-Shub bit sequencer: squares the state, hands the
//               square to an external mod-n reducer, emits one bit per request.
//               Define BBS_PARITY_OUT_EN to emit the parity of the new state
//               instead of its LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module bbs_sequencer
    import bbs_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   seed_load,
    input  logic [X_W-1:0]         seed,
    input  logic                   bit_req,
    output logic                   bit_valid,
    output logic                   bit_out,
    output logic                   busy,
    output logic                   err,
    output logic [X_W-1:0]         x_out,
    bbs_sequencer_if.master        mod_bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic              err_q, err_d;
    logic [TO_W-1:0]   tmo_q, tmo_d;
    logic [PROD_W-1:0] mod_a_q, mod_a_d;
    logic              mod_start_q, mod_start_d;

    logic              mul_start;
    logic              mul_done;
    logic [PROD_W-1:0] mul_product;
    logic              new_bit;

    bbs_square_mul u_square_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (x_q),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            x_q         <= X_RESET;
            err_q       <= 1'b0;
            tmo_q       <= '0;
            mod_a_q     <= '0;
            mod_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            mod_a_q     <= mod_a_d;
            mod_start_q <= mod_start_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        err_d       = err_q;
        tmo_d       = tmo_q;
        mod_a_d     = mod_a_q;
        mod_start_d = 1'b0;
        mul_start   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (seed_load) begin
                    x_d   = sanitize_seed(seed);
                    err_d = 1'b0;
                end else if (bit_req) begin
                    mul_start = 1'b1;
                    state_d   = ST_SQUARE;
                end
            end
            ST_SQUARE: begin
                if (mul_done) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // mod_a is only rewritten here, which keeps it stable for the
                // whole reducer transaction.
                mod_a_d     = mul_product;
                mod_start_d = 1'b1;
                tmo_d       = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                if (mod_bus.mod_done) begin
                    x_d     = mod_bus.mod_result;
                    state_d = ST_EMIT;
                end else if (tmo_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_EMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef BBS_PARITY_OUT_EN
    assign new_bit = ^x_q;
`else
    assign new_bit = x_q[0];
`endif

    always_comb begin
        busy      = (state_q != ST_IDLE);
        bit_valid = (state_q == ST_EMIT);
        bit_out   = 1'b0;
        if (state_q == ST_EMIT) begin
            bit_out = new_bit;
        end
    end

    assign err               = err_q;
    assign x_out             = x_q;
    assign mod_bus.mod_start = mod_start_q;
    assign mod_bus.mod_a     = mod_a_q;

endmodule
`default_nettype wire

// File: tb/tb_bbs_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bbs_sequencer
// Description : Self-checking bench for bbs_sequencer with a behavioural
//               mod-n reducer answering 3 cycles after mod_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bbs_sequencer;

    localparam int unsigned TIMEOUT = 255;
    localparam logic [63:0] MOD_N   = 64'd2147483647 * 64'd2147483629;

    logic        clk = 1'b0;
    logic        rst;
    logic        seed_load;
    logic [63:0] seed;
    logic        bit_req;
    logic        bit_valid;
    logic        bit_out;
    logic        busy;
    logic        err;
    logic [63:0] x_out;

    bbs_sequencer_if bus ();

    bbs_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .seed      (seed),
        .bit_req   (bit_req),
        .bit_valid (bit_valid),
        .bit_out   (bit_out),
        .busy      (busy),
        .err       (err),
        .x_out     (x_out),
        .mod_bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [63:0] exp_x;
    logic        exp_err;

    // Reducer model controls
    bit          withhold   = 1'b0;
    int          inject_req = 0;
    int          inject_ack = 0;
    int          dly        = 0;
    logic [127:0] cap_a;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic expected_bit(input logic [63:0] x);
`ifdef BBS_PARITY_OUT_EN
        return ($countones(x) % 2) == 1;
`else
        return (x % 64'd2) == 64'd1;
`endif
    endfunction

    // Reducer: answers x*x mod n three cycles after seeing mod_start.
    initial begin
        bus.mod_done   = 1'b0;
        bus.mod_result = '0;
        forever begin
            tick();
            bus.mod_done = 1'b0;
            if (inject_req != inject_ack) begin
                inject_ack     = inject_req;
                bus.mod_result = 64'hDEAD_BEEF_0000_1234;
                bus.mod_done   = 1'b1;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin
                    bus.mod_result = 64'(cap_a % {64'd0, MOD_N});
                    bus.mod_done   = 1'b1;
                end
            end
            if (bus.mod_start && !withhold) begin
                cap_a = bus.mod_a;
                dly   = 3;
            end
        end
    end

    task automatic load_seed(input logic [63:0] s);
        seed      = s;
        seed_load = 1'b1;
        tick();
        seed_load = 1'b0;
        exp_x     = (s < 64'd2) ? 64'd3 : s;
        exp_err   = 1'b0;
        check_val("seed_x", 128'(x_out), 128'(exp_x));
        check_val("seed_err", 128'(err), 128'(exp_err));
    endtask

    // One bit request; expect_done=0 means the reducer is withholding.
    task automatic run_bit(input bit expect_done, input bit poke);
        int           k;
        int           j;
        int           nv;
        logic [127:0] sq;
        nv      = 0;
        bit_req = 1'b1;
        tick();
        bit_req = 1'b0;
        k = 0;
        while (!bus.mod_start && k < 200) begin
            if (poke && k == 10) begin
                bit_req = 1'b1; seed_load = 1'b1; seed = 64'h1234;
            end
            if (poke && k == 11) begin
                bit_req = 1'b0; seed_load = 1'b0;
            end
            if (poke && k == 30) check_val("x_hold_square", 128'(x_out), 128'(exp_x));
            if (bit_valid) nv++;
            tick();
            k++;
        end
        sq = {64'd0, exp_x} * {64'd0, exp_x};
        check_val("lat_start", 128'(k), 128'd65);
        check_val("mod_a", bus.mod_a, sq);
        j = 0;
        while (!bit_valid && busy && j < int'(TIMEOUT) + 20) begin
            if (j == 2) check_val("x_hold_wait", 128'(x_out), 128'(exp_x));
            tick();
            j++;
        end
        if (expect_done) begin
            exp_x = 64'(sq % {64'd0, MOD_N});
            check_val("lat_emit", 128'(j), 128'd4);
            check_val("emit_x", 128'(x_out), 128'(exp_x));
            check_val("emit_bit", 128'(bit_out), 128'(expected_bit(exp_x)));
            check_val("mod_a_held", bus.mod_a, sq);
            tick();
            check_val("valid_pulse", 128'(bit_valid), 128'd0);
        end else begin
            exp_err = 1'b1;
            check_val("timeout_len", 128'(j), 128'(TIMEOUT));
            check_val("timeout_valid", 128'(bit_valid), 128'd0);
            check_val("timeout_x", 128'(x_out), 128'(exp_x));
        end
        for (int i = 0; i < 5; i++) begin
            if (bit_valid || busy) nv++;
            tick();
        end
        check_val("extra_activity", 128'(nv), 128'd0);
        check_val("idle_err", 128'(err), 128'(exp_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_x"}, 128'(x_out), 128'd3);
        check_val({tag, "_flags"}, 128'({bit_valid, bit_out, busy, err, bus.mod_start}), 128'd0);
        check_val({tag, "_mod_a"}, bus.mod_a, 128'd0);
    endtask

    initial begin
        int k;
        int nv;
        logic [63:0] s;
        rst       = 1'b1;
        seed_load = 1'b0;
        bit_req   = 1'b0;
        seed      = '0;
        exp_x     = 64'd3;
        exp_err   = 1'b0;
        tick(); tick(); tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        load_seed(64'd5);
        run_bit(1'b1, 1'b0);
        check_val("seed5_x25", 128'(x_out), 128'd25);

        load_seed(64'h1_0000_0000);
        run_bit(1'b1, 1'b0);

        load_seed(64'd0);
        run_bit(1'b1, 1'b0);
        check_val("seed0_x9", 128'(x_out), 128'd9);

        load_seed(64'd1);

        // seed_load beats bit_req when both arrive in IDLE
        seed = 64'd7; seed_load = 1'b1; bit_req = 1'b1;
        tick();
        seed_load = 1'b0; bit_req = 1'b0;
        exp_x = 64'd7;
        tick();
        check_val("both_busy", 128'(busy), 128'd0);
        check_val("both_x", 128'(x_out), 128'd7);

        run_bit(1'b1, 1'b1);

        withhold = 1'b1;
        run_bit(1'b0, 1'b0);
        withhold = 1'b0;
        load_seed(64'd11);

        // Reset in the middle of WAIT, followed by a stray mod_done
        withhold = 1'b1;
        bit_req  = 1'b1;
        tick();
        bit_req = 1'b0;
        k = 0;
        while (!bus.mod_start && k < 200) begin tick(); k++; end
        check_val("rst_wait_start", 128'(k), 128'd65);
        tick(); tick(); tick();
        rst = 1'b1;
        #2;
        check_reset_outputs("rst_async");
        tick();
        rst = 1'b0;
        inject_req++;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bit_valid || busy) nv++;
        end
        check_val("late_done_ignored", 128'(nv), 128'd0);
        check_reset_outputs("post_rst");
        withhold = 1'b0;
        exp_x    = 64'd3;
        exp_err  = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 0) begin
                s = (i == 0) ? 64'd1 : {$urandom, $urandom};
                load_seed(s);
            end
            run_bit(1'b1, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bbs_sequencer.md
BBS_SEQUENCER -- requirements
Module: bbs_sequencer

Interface
REQ-001 SHALL have these ports (name direction width meaning), clock and reset first:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- seed_load  in  1  load seed into state register.
- seed  in  64  initial BBS state x0.
- bit_req  in  1  request one output bit.
- bit_valid  out  1  one-cycle strobe; bit_out is valid.
- bit_out  out  1  generated bit.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky flag; set on reducer timeout.
- mod_start  out  1  one-cycle start pulse to the mod-n reducer.
- mod_a  out  128  x*x operand for the reducer.
- mod_result  in  64  reduced value x*x mod n.
- mod_done  in  1  one-cycle strobe from the reducer; mod_result is valid.
- x_out  out  64  current state register.
REQ-002 SHALL expose parameter TIMEOUT, default 255, giving the maximum number of WAIT cycles before abort.

Function
REQ-003 SHALL implement the FSM states IDLE, SQUARE, ISSUE, WAIT and EMIT.
REQ-004 IDLE with seed_load=1: x <= seed; seed 0 or 1 SHALL be replaced by 64'd3; no bit is produced.
REQ-005 IDLE with bit_req=1 and seed_load=0: go to SQUARE and clear the square accumulator; if both are high in the same cycle, seed_load SHALL win.
REQ-006 SQUARE: shift-add 64x64 multiply, one multiplier bit per cycle, exactly 64 cycles, exact 128-bit result with no truncation.
REQ-007 ISSUE: mod_a <= product, mod_start=1 for exactly one cycle, then go to WAIT.
REQ-008 mod_a SHALL be held stable from ISSUE until the cycle after mod_done.
REQ-009 WAIT: on mod_done, x <= mod_result and go to EMIT; mod_done seen in any other state SHALL be ignored.
REQ-010 EMIT: bit_valid=1 for one cycle, bit_out per REQ-017, then go to IDLE.
REQ-011 bit_req or seed_load outside IDLE SHALL be ignored; requests are not queued.
REQ-012 Latency: bit_req sampled at cycle 0 gives mod_start at cycle 65; bit_valid asserts the cycle after mod_done is sampled.
REQ-013 WAIT cycle counter: if TIMEOUT cycles pass with no mod_done, set err, keep x unchanged, go to IDLE, and assert no bit_valid.
REQ-014 err SHALL be cleared only by rst or by seed_load.

Reset
REQ-015 On rst assertion, regardless of state: FSM=IDLE, x=64'd3, bit_valid=0, bit_out=0, busy=0, err=0, mod_start=0, mod_a=0, accumulator=0, timeout counter=0.
REQ-016 Reset in the middle of SQUARE or WAIT SHALL discard the operation; a mod_done arriving after reset deassertion SHALL be ignored (FSM is in IDLE).

Configuration
REQ-017 With macro BBS_PARITY_OUT_EN defined, bit_out = XOR of all 64 bits of the new x; without it, bit_out = LSB of the new x. Timing is identical in both builds.

Structure
REQ-018 Shared package bbs_pkg SHALL hold the constants P=2147483647, Q=2147483629 and N=P*Q as a 64-bit value, the width constants (64, 128), and the FSM state typedef.
REQ-019 The multiplier SHALL be a sub-module bbs_square_mul with start/done handshake, 64-bit operand and 128-bit product; the FSM, timeout and output logic SHALL remain in bbs_sequencer.

Verification
REQ-020 The bench SHALL cover at least these directed scenarios, with a behavioural reducer model responding 3 cycles after mod_start:
- seed_load seed=5, bit_req -> mod_a=25 at cycle 65; model returns 25 -> x=25, bit_out=1 (LSB) or 1 (parity, three set bits).
- seed_load seed=64'h1_0000_0000, bit_req -> mod_a=128'h1_0000_0000_0000_0000 exactly (no truncation).
- seed_load seed=0 -> x_out=3; bit_req -> mod_a=9.
- bit_req and seed_load pulsed during SQUARE -> ignored; exactly one bit_valid; x_out unchanged until EMIT.
- model withholds mod_done -> err=1 after 255 WAIT cycles, FSM back in IDLE, no bit_valid; seed_load clears err.
- rst asserted during WAIT, then a late mod_done -> all outputs at reset values, x_out=3, no bit_valid.
